// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: sample-rate buffer between the audio byte stream and
// the PWM audio DAC stage. A DEPTH-entry FIFO absorbs bursty upstream writes,
// and a free-running divider releases one sample every DIV clocks onto the
// registered sample_value output. Ticks that find the FIFO empty are counted
// as underruns in a saturating counter.
// Build option: define AUDIO_UNDERRUN_MUTE_EN to force sample_value to
// mid-scale (8'h80) on an underrun. Without it, the previous sample is held.
module audio_sample_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DIV    = 1144,
  parameter int DIV_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        sample_value,
  output logic              sample_tick,
  output logic [ADDR_W:0]   fifo_level,
  output logic [7:0]        underrun_count
);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [ADDR_W:0]  FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]       MID_SCALE  = 8'h80;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DIV_W-1:0]  div_cnt;
  logic              push;
  logic              pop;
  logic              underrun;

  // Upstream may write whenever a slot is free; nothing is accepted in reset.
  assign in_ready    = rst_n && (fifo_level != FULL_LEVEL);
  assign sample_tick = rst_n && enable && (div_cnt == DIV_LAST);
  assign push        = in_valid && in_ready;
  // A tick and a push in the same cycle never bypass: the pop decision looks
  // only at the level held before this edge.
  assign pop         = sample_tick && (fifo_level != '0);
  assign underrun    = sample_tick && (fifo_level == '0);

  // Sample-period divider; parked at zero while disabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable once the pointers and level are cleared, and leaving it
    // reset-free lets it map onto RAM.
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leave the level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sample output register and saturating underrun counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_value   <= MID_SCALE;
      underrun_count <= '0;
    end else begin
      if (pop) begin
        sample_value <= mem[rd_ptr];
      end
`ifdef AUDIO_UNDERRUN_MUTE_EN
      else if (underrun) begin
        sample_value <= MID_SCALE;
      end
`endif
      if (underrun && (underrun_count != 8'hFF)) begin
        underrun_count <= underrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder with a short sample period.
// A queue holds the bytes the FIFO should contain; each tick pops the
// expected release and the following cycle compares it on sample_value.
module tb_audio_sample_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DIV    = 4;
  localparam int DIV_W  = 11;
`ifdef AUDIO_UNDERRUN_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        sample_value;
  logic              sample_tick;
  logic [ADDR_W:0]   fifo_level;
  logic [7:0]        underrun_count;

  audio_sample_feeder #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sample_value  (sample_value),
    .sample_tick   (sample_tick),
    .fifo_level    (fifo_level),
    .underrun_count(underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference state.
  logic [7:0] q[$];
  logic [7:0] exp_val;
  int         cnt_m;
  int         uc_m;
  bit         pend;
  int         total;
  int         bad;

  // One clock: model update and scoreboard compare at the negedge, then
  // return just after the next posedge so the caller can drive inputs.
  task automatic step();
    int  size_before;
    bit  tick_exp;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      exp_val = 8'h80;
      cnt_m   = 0;
      uc_m    = 0;
      pend    = 1'b0;
    end else begin
      if (pend) begin
        total++;
        if (sample_value !== exp_val) begin
          bad++;
          $display("FAIL release: got=%h exp=%h t=%0t", sample_value, exp_val, $time);
        end
        pend = 1'b0;
      end
      tick_exp = enable && (cnt_m == DIV - 1);
      total++;
      if (sample_tick !== tick_exp) begin
        bad++;
        $display("FAIL tick_timing: got=%b exp=%b t=%0t", sample_tick, tick_exp, $time);
      end
      size_before = q.size();
      if (tick_exp) begin
        if (size_before > 0) begin
          exp_val = q.pop_front();
        end else begin
          if (uc_m < 255) uc_m++;
          if (MUTE) exp_val = 8'h80;
        end
        pend = 1'b1;
      end
      cnt_m = !enable ? 0 : ((cnt_m == DIV - 1) ? 0 : cnt_m + 1);
      if (in_valid && (size_before != DEPTH)) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL reset_in_ready: got=%b exp=0", in_ready);
      end
    end
    total++;
    if (sample_value !== 8'h80) begin
      bad++; $display("FAIL reset_sample: got=%h exp=80", sample_value);
    end
    total++;
    if (fifo_level !== 5'd0) begin
      bad++; $display("FAIL reset_level: got=%0d exp=0", fifo_level);
    end
    total++;
    if (underrun_count !== 8'h00) begin
      bad++; $display("FAIL reset_underrun: got=%h exp=00", underrun_count);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_in_ready: got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_ordered();
    logic [7:0] vals[3];
    logic [7:0] prev;
    int         chg_at[$];
    logic [7:0] chg_val[$];
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      step();
    end
    in_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd3) begin
      bad++; $display("FAIL ordered_level: got=%0d exp=3", fifo_level);
    end
    enable = 1'b1;
    prev = sample_value;
    for (int i = 0; i < 3 * DIV; i++) begin
      step();
      if (sample_value !== prev) begin
        chg_at.push_back(i);
        chg_val.push_back(sample_value);
      end
      prev = sample_value;
    end
    enable = 1'b0;
    total++;
    if (chg_at.size() != 3) begin
      bad++; $display("FAIL ordered_steps: got=%0d exp=3", chg_at.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (chg_val[k] !== vals[k] || chg_at[k] != DIV - 1 + k * DIV) begin
          bad++;
          $display("FAIL ordered_step%0d: got=%h@%0d exp=%h@%0d", k, chg_val[k], chg_at[k],
                   vals[k], DIV - 1 + k * DIV);
        end
      end
    end
    step();
    total++;
    if (underrun_count !== 8'h00 || fifo_level !== 5'd0) begin
      bad++; $display("FAIL ordered_end: got uc=%h lvl=%0d exp uc=00 lvl=0", underrun_count, fifo_level);
    end
  endtask

  task automatic test_full();
    bit found;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      step();
    end
    total++;
    if (fifo_level !== 5'd16 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_flags: got lvl=%0d rdy=%b exp lvl=16 rdy=0", fifo_level, in_ready);
    end
    in_data = 8'hEE;
    step();
    step();
    in_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd16) begin
      bad++; $display("FAIL full_overflow: got=%0d exp=16", fifo_level);
    end
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      #1;
      if (sample_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL full_tick_timeout: got=none exp=tick");
    end else begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL full_tick_ready: got=%b exp=0", in_ready);
      end
      step();
      total++;
      if (in_ready !== 1'b1 || fifo_level !== 5'd15) begin
        bad++; $display("FAIL full_after_tick: got rdy=%b lvl=%0d exp rdy=1 lvl=15", in_ready, fifo_level);
      end
    end
    for (int i = 0; i < 200 && q.size() > 0; i++) step();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL full_drain_timeout: got=%0d left exp=0", q.size());
    end
    enable = 1'b0;
    step();
    total++;
    if (sample_value !== 8'h4F) begin
      bad++; $display("FAIL full_last: got=%h exp=4f", sample_value);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] exp_s;
    exp_s = MUTE ? 8'h80 : 8'h4F;
    enable = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) step();
    total++;
    if (underrun_count !== 8'd3) begin
      bad++; $display("FAIL underrun_count: got=%0d exp=3", underrun_count);
    end
    total++;
    if (sample_value !== exp_s) begin
      bad++; $display("FAIL underrun_sample: got=%h exp=%h", sample_value, exp_s);
    end
  endtask

  task automatic test_push_on_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      #1;
      if (sample_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL push_tick_timeout: got=none exp=tick");
    end else begin
      in_valid = 1'b1; in_data = 8'h55;
      step();
      in_valid = 1'b0;
      total++;
      if (underrun_count !== 8'd4 || fifo_level !== 5'd1) begin
        bad++; $display("FAIL push_tick_store: got uc=%0d lvl=%0d exp uc=4 lvl=1", underrun_count, fifo_level);
      end
      for (int i = 0; i < DIV; i++) step();
      total++;
      if (sample_value !== 8'h55 || fifo_level !== 5'd0) begin
        bad++; $display("FAIL push_tick_release: got=%h lvl=%0d exp=55 lvl=0", sample_value, fifo_level);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300 * DIV; i++) step();
    enable = 1'b0;
    step();
    total++;
    if (underrun_count !== 8'hFF || uc_m != 255) begin
      bad++; $display("FAIL underrun_saturate: got=%h exp=ff", underrun_count);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (fifo_level !== 5'd5) begin
      bad++; $display("FAIL mid_reset_fill: got=%0d exp=5", fifo_level);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    total++;
    if (fifo_level !== 5'd0 || sample_value !== 8'h80 || underrun_count !== 8'h00) begin
      bad++; $display("FAIL mid_reset_state: got lvl=%0d smp=%h uc=%h exp lvl=0 smp=80 uc=00",
                      fifo_level, sample_value, underrun_count);
    end
    enable = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) step();
    enable = 1'b0;
    step();
    total++;
    if (sample_value !== 8'h80 || underrun_count !== 8'd3 || fifo_level !== 5'd0) begin
      bad++; $display("FAIL mid_reset_stale: got smp=%h uc=%0d lvl=%0d exp smp=80 uc=3 lvl=0",
                      sample_value, underrun_count, fifo_level);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    exp_val = 8'h80; cnt_m = 0; uc_m = 0; pend = 1'b0;
    test_reset();
    test_ordered();
    test_full();
    test_underrun();
    test_push_on_tick();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound in case the DUT stalls the stimulus.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
